// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: instruction constants and the fetch buffer entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Clears the byte-offset bits so the result is a word address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Instruction buffer: synchronous FIFO of fetch entries with flush.
// Latency: a push is visible at the head the cycle after it is written (no bypass).
// Backpressure: none internally; the owner must not push when full. Flush beats push.
module fetch_buf
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o,
  output logic         empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // A flush discards everything, including anything arriving in the same cycle.
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ifetch_unit.sv
// Fetch front-end: owns the PC, requests imem words, buffers in-order responses for IF/ID.
// Latency: a response reaches the outputs one cycle after it arrives; first request right out of reset.
// Backpressure: stall freezes the head; requests stop once in-flight + buffered reaches BUF_DEPTH.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  // Address of the next live (non-stale) response, so the FIFO entry gets its PC.
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] stale_q, stale_d;

  logic [CW-1:0] buf_count;
  logic          buf_empty;
  logic [CW:0]   credits_used;
  logic          req_accept;
  logic          resp_live;
  logic          resp_drop;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Credits cover both buffered words and words still in flight, so the FIFO never overflows.
  assign credits_used   = {1'b0, outstanding_q} + {1'b0, buf_count};
  assign imem_req_valid = credits_used < (CW+1)'(BUF_DEPTH);
  assign imem_req_addr  = fetch_pc_q;
  assign req_accept     = imem_req_valid && imem_req_ready;

  assign resp_live = imem_resp_valid && (stale_q == '0);
  assign resp_drop = imem_resp_valid && (stale_q != '0);
  assign pop       = instr_valid && !stall;

  assign push_entry.pc    = resp_pc_q;
  assign push_entry.instr = imem_resp_data;

  // Next-state for PC, response tracking and counters; redirect overrides every other update.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CW'(req_accept) - CW'(imem_resp_valid);
    stale_d       = stale_q;

    if (req_accept) fetch_pc_d = fetch_pc_q + PC_STEP;
    if (resp_live)  resp_pc_d  = resp_pc_q + PC_STEP;
    if (resp_drop)  stale_d    = stale_q - CW'(1);

    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      resp_pc_d  = word_align(redirect_pc);
      // Everything still in flight after this edge, including a request accepted now, is wrong-path.
      stale_d    = outstanding_d;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC_ALIGNED;
      resp_pc_q     <= RESET_PC_ALIGNED;
      outstanding_q <= '0;
      stale_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (resp_live),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .count_o     (buf_count),
    .empty_o     (buf_empty)
  );

  // An empty buffer presents a NOP bubble at PC 0.
  assign instr_valid = !buf_empty;
  assign pc_out      = buf_empty ? 32'h0 : head.pc;
  assign instr_out   = buf_empty ? NOP_INSTR : head.instr;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: random-latency in-order memory plus an epoch-based reference model.
module tb_ifetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;

  ifetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .pc_out          (pc_out),
    .instr_out       (instr_out),
    .instr_valid     (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int DEPTH = 4;

  // One request held by the memory model, tagged with the redirect epoch it was issued in.
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] buf_q[$];      // PCs expected to be sitting in the instruction buffer, in order
  logic [31:0] model_pc;      // next address the unit should request
  logic [31:0] seq_pc;        // next PC expected to leave the unit
  int          epoch;
  int          cyc;
  int          tests;
  int          fails;
  int          lat_min, lat_max;
  bit          rdy_rand;
  bit          hold_prev;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mem_q.delete();
    buf_q.delete();
    model_pc  = 32'h0000_0000;
    seq_pc    = 32'h0000_0000;
    epoch     = epoch + 1;
    hold_prev = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"},   {31'h0, imem_req_valid}, 32'h1);
    check({tag, "_req_addr"},    imem_req_addr, 32'h0);
    check({tag, "_pc_out"},      pc_out, 32'h0);
    check({tag, "_instr_out"},   instr_out, 32'h0);
    check({tag, "_instr_valid"}, {31'h0, instr_valid}, 32'h0);
  endtask

  // One clock cycle: check outputs mid-cycle, drive inputs for the coming edge, advance the model.
  task automatic do_cycle(input bit redir, input logic [31:0] rpc, input bit stl);
    bit          exp_valid;
    bit          pop;
    bit          resp;
    bit          rdy;
    bit          accept;
    mreq_t       e;
    logic [31:0] head_pc;

    @(negedge clk);
    exp_valid = (buf_q.size() > 0);
    head_pc   = exp_valid ? buf_q[0] : 32'h0;
    check("instr_valid", {31'h0, instr_valid}, {31'h0, exp_valid});
    check("pc_out", pc_out, head_pc);
    check("instr_out", instr_out, exp_valid ? mem_word(head_pc) : 32'h0);
    check("req_valid", {31'h0, imem_req_valid},
          {31'h0, ((mem_q.size() + buf_q.size()) < DEPTH)});
    if (imem_req_valid) check("req_addr", imem_req_addr, model_pc);
    if (hold_prev) begin
      check("hold_valid", {31'h0, imem_req_valid}, 32'h1);
      check("hold_addr", imem_req_addr, prev_addr);
    end

    pop = exp_valid && !stl;
    if (pop) begin
      check("pc_seq", pc_out, seq_pc);
      seq_pc = seq_pc + 32'd4;
    end

    resp = 1'b0;
    e    = '{addr: 32'h0, due: 0, epoch: -1};
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      resp = 1'b1;
      e    = mem_q.pop_front();
    end
    rdy    = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
    accept = imem_req_valid && rdy;

    imem_req_ready  = rdy;
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(e.addr) : $urandom;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    stall           = stl;

    if (pop) void'(buf_q.pop_front());
    if (resp && e.epoch == epoch && !redir) begin
      check("no_overflow", {31'h0, (buf_q.size() < DEPTH)}, 32'h1);
      buf_q.push_back(e.addr);
    end
    if (accept)
      mem_q.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(lat_max, lat_min),
                        epoch: epoch});
    if (redir) begin
      buf_q.delete();
      epoch    = epoch + 1;
      model_pc = rpc & ~32'h3;
      seq_pc   = model_pc;
    end else if (accept) begin
      model_pc = model_pc + 32'd4;
    end
    hold_prev = imem_req_valid && !rdy && !redir;
    prev_addr = imem_req_addr;
    cyc++;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; epoch = 0;
    lat_min = 1; lat_max = 1; rdy_rand = 1'b0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    model_reset();

    // Reset: outputs at their reset values while rst_n is low.
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Always-ready memory, latency 1: sustained one instruction per cycle.
    for (int i = 0; i < 12; i++) do_cycle(1'b0, 32'h0, 1'b0);

    // Stall held for 5 cycles mid-stream.
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 32'h0, 1'b0);

    // Redirect coinciding with a request acceptance and a response.
    do_cycle(1'b1, 32'h0000_2000, 1'b0);
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 32'h0, 1'b0);

    // Latency 3 with requests in flight, then redirect to an unaligned target.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 32'h0, 1'b0);
    do_cycle(1'b1, 32'h0000_0101, 1'b0);
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 32'h0, 1'b0);

    // Random ready, latency 1-4, occasional stalls and redirects.
    lat_min = 1; lat_max = 4; rdy_rand = 1'b1;
    for (int i = 0; i < 400; i++)
      do_cycle(($urandom_range(99) < 3), $urandom, ($urandom_range(99) < 20));

    // PC wrap from 0xFFFF_FFFC to 0.
    lat_min = 2; lat_max = 2; rdy_rand = 1'b0;
    do_cycle(1'b1, 32'hFFFF_FFF6, 1'b0);
    for (int i = 0; i < 12; i++) do_cycle(1'b0, 32'h0, 1'b0);

    // Asynchronous reset pulse mid-stream, away from any clock edge.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    stall           = 1'b0;
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    lat_min = 1; lat_max = 3; rdy_rand = 1'b1;
    for (int i = 0; i < 30; i++) do_cycle(1'b0, 32'h0, ($urandom_range(99) < 15));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch front-end of the MIPS pipeline, directly upstream of the IF/ID pipeline register. Owns the fetch PC, issues word-aligned requests to instruction memory over a valid/ready handshake, and buffers in-order responses in a small FIFO. Presents one `{pc, instr}` pair per cycle to IF/ID, inserting a NOP bubble (32'h0) when empty. Handles hazard-unit stalls and branch/jump redirects, including squashing in-flight wrong-path fetches.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `BUF_DEPTH`, 4: instruction buffer entries; power of 2, ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  fetch byte address, bits [1:0] always 0.
- `imem_resp_valid`  in  1  instruction word returned; in order, ≥1 cycle after acceptance.
- `imem_resp_data`  in  32  instruction word.
- `redirect_valid`  in  1  branch/jump taken; restart fetch.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored (forced 0).
- `stall`  in  1  hazard unit holds IF/ID; do not pop.
- `pc_out`  out  32  PC of presented instruction; 0 on bubble.
- `instr_out`  out  32  presented instruction; 32'h0 (NOP) on bubble.
- `instr_valid`  out  1  buffer head is a real instruction.

## Operation
- State: `fetch_pc`, `outstanding` count, `stale` count (both `$clog2(BUF_DEPTH)+1` bits), FIFO.
- `imem_req_valid = (outstanding + count) < BUF_DEPTH`. Registered state only; no combinational path from `stall`, `redirect_valid`, or responses.
- Request accepted (`valid && ready`): `fetch_pc += 4` (32-bit wrap), `outstanding++`.
- Response with `stale == 0`: push `{addr, data}` into the FIFO; `outstanding--`. Each request's address is carried in a parallel address queue or recomputed from a tail PC.
- Response with `stale > 0`: discard, `stale--`, `outstanding--`.
- Pop: `instr_valid && !stall`. Outputs are combinational from the FIFO head.
- Redirect (priority over everything):
  - `fetch_pc <= redirect_pc & ~3`.
  - FIFO flushed, including the head.
  - `stale <= outstanding` after this cycle's accept and response updates, so a request accepted in the redirect cycle is also stale.
  - IF/ID captures the presented head on the redirect edge; squashing that capture is the decode/hazard logic's job.
- Simultaneous push and pop: both happen; count unchanged.
- FIFO overflow is impossible by credit rule. A bench assertion fires on a response with FIFO full, or with `outstanding == 0`.

## Timing
- Reset values:
  - `fetch_pc = RESET_PC`; counters 0; FIFO empty.
  - Outputs: `imem_req_valid = 1`, `imem_req_addr = RESET_PC`, `pc_out = 0`, `instr_out = 0`, `instr_valid = 0`.
- First request is valid in the first cycle after `rst_n` deasserts.
- Response to output latency: 1 cycle (registered push, no bypass).
- Throughput: 1 instruction/cycle sustained if `BUF_DEPTH ≥ mem_latency + 2`.
- After a redirect, the first new-path request issues the next cycle if credits allow.
- Reset mid-operation clears all state immediately. The memory system must be reset concurrently and return no responses for pre-reset requests.
- `stall` held: outputs stable, fetch continues until credits are exhausted.

## Structure
- Shared package `mips_pkg`: `NOP_INSTR = 32'h0000_0000`, `PC_STEP = 4`, `DEFAULT_RESET_PC`, and a struct `fetch_entry_t { pc[31:0], instr[31:0] }`.
- One sub-module, `fetch_buf`: synchronous FIFO of `fetch_entry_t`, parameterised depth, with push/pop/flush, `count`, and `empty` outputs. Flush has priority over push.

## Test plan
- Reset, memory always ready, 1-cycle latency, `stall = 0`: requests 0x0, 0x4, 0x8… on consecutive cycles. `pc_out` 0x0 with `instr_valid` two cycles after reset release, then one instruction per cycle.
- Hold `stall` high for 5 cycles mid-stream: `pc_out`/`instr_out` constant. `imem_req_valid` drops once `outstanding + count == 4`. No instruction lost or duplicated after release.
- Memory latency 3, two requests in flight, redirect to 0x0000_0101: both stale responses dropped. Next request address 0x0000_0100. First valid output is `pc_out = 0x100`.
- Redirect in the same cycle as a request acceptance and a response: accepted request counted stale. FIFO empty next cycle. No stale word ever appears at the output.
- `imem_req_ready` toggling randomly, random latency 1–4: output PC sequence strictly +4 between redirects. `imem_req_addr` held stable while valid and not ready.
- `fetch_pc` 0xFFFF_FFFC accepted: next request address 0x0000_0000. Async `rst_n` pulse mid-stream: outputs return to reset values immediately.
